multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the RV32 datapath (R-type, lw, sw, beq). Steps FETCH/DECODE/EXEC/MEM/WB over several clocks.
//  Drives mux selects, register write strobes and a req/ready memory handshake that tolerates wait states.
//  Flags illegal opcodes and memory timeouts; counts retired instructions. Sits between IR/datapath and the shared memory.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a mem request may wait for ready; 0 = timeout disabled
//  CNT_W        32  width of instret counter
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  opcode      in   7      IR[6:0]; stable from cycle after ir_write until next FETCH
//  zero        in   1      ALU zero flag (combinational)
//  mem_ready   in   1      memory completes current request this cycle
//  mem_req     out  1      memory request valid
//  mem_we      out  1      1 = write (valid with mem_req)
//  iord        out  1      mem addr select: 0 = PC, 1 = ALUOut
//  ir_write    out  1      load IR from mem rdata
//  aluout_we   out  1      load ALUOut register
//  alu_src_a   out  1      0 = PC, 1 = rs1
//  alu_src_b   out  1      0 = rs2, 1 = imm
//  alu_op      out  2      00 add, 01 sub, 10 funct decode
//  reg_write   out  1      regfile write enable
//  mem2reg     out  1      WB data: 0 = ALUOut, 1 = MDR
//  pc_write    out  1      update PC
//  pc_src      out  1      next PC: 0 = PC+4 (dedicated adder), 1 = ALUOut
//  retire      out  1      one-cycle pulse per completed instruction
//  instret     out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
//  fault       out  1      sticky fault flag
//  fault_code  out  2      00 none, 01 illegal opcode, 10 mem timeout
//  state_dbg   out  4      current state encoding
// BEHAVIOUR
//  Reset: while rst=1 every output is 0; state<=FETCH, instret<=0, fault<=0, timeout count<=0. rst mid-instruction aborts it, no retire.
//  States/transitions; unlisted outputs are 0:
//   FETCH   : mem_req=1, iord=0. On mem_ready: ir_write=1 -> DECODE; else stay.
//   DECODE  : alu_src_a=0, alu_src_b=1, alu_op=00, aluout_we=1 (branch target). Next by opcode:
//             0110011->EXEC_R; 0000011/0100011->MEM_ADDR; 1100011->BRANCH; other->FAULT(code 01).
//   EXEC_R  : alu_src_a=1, alu_src_b=0, alu_op=10, aluout_we=1 -> R_WB.
//   R_WB    : reg_write=1, mem2reg=0, pc_write=1, pc_src=0, retire=1 -> FETCH.
//   MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_op=00, aluout_we=1 -> MEM_RD (lw) / MEM_WR (sw).
//   MEM_RD  : mem_req=1, iord=1, mem_we=0. On mem_ready (datapath captures MDR) -> LD_WB.
//   LD_WB   : reg_write=1, mem2reg=1, pc_write=1, pc_src=0, retire=1 -> FETCH.
//   MEM_WR  : mem_req=1, mem_we=1, iord=1. On mem_ready: pc_write=1, pc_src=0, retire=1 -> FETCH.
//   BRANCH  : alu_src_a=1, alu_src_b=0, alu_op=01, aluout_we=0 (target preserved);
//             pc_write=1, pc_src=zero, retire=1 -> FETCH.
//   FAULT   : all strobes 0, fault=1, fault_code held; exit only via rst.
//  Handshake: mem_req held continuously, mem_we/iord stable, until the cycle mem_ready=1; that cycle is the transfer.
//   mem_ready while mem_req=0 is ignored. Strobes gated by mem_ready (ir_write, MEM_WR pc_write/retire) are Mealy.
//  Latency (zero-wait memory): R=4, lw=5, sw=4, beq=3 cycles. Each wait cycle adds 1.
//  Timeout: counter clears on entering FETCH/MEM_RD/MEM_WR; increments each cycle mem_req=1 && !mem_ready.
//   Reaching MEM_TIMEOUT -> FAULT(code 10) next cycle. mem_ready on that same cycle wins (transfer completes, no fault).
//  instret increments on retire; wraps all-ones -> 0.
//  state_dbg: FETCH 0, DECODE 1, EXEC_R 2, R_WB 3, MEM_ADDR 4, MEM_RD 5, LD_WB 6, MEM_WR 7, BRANCH 8, FAULT 15.
// STRUCTURE
//  Package riscv_ctrl_pkg: opcode constants (R/LOAD/STORE/BRANCH), state encodings, ALU_OP_* and FAULT_* codes.
//  Sub-module mem_timeout_ctr (clear, inc, param MEM_TIMEOUT, expired out). FSM, output decode and instret stay in the top.
// TESTING
//  Reset, then R-type (0110011), zero-wait mem -> states 0,1,2,3; one reg_write; retire; instret=1.
//  lw, mem_ready delayed 3 cycles -> mem_req/iord=1 held 4 cycles in MEM_RD; LD_WB mem2reg=1; total 8 cycles.
//  beq zero=1, then beq zero=0 -> BRANCH pc_src=1, then pc_src=0; aluout_we=0 in BRANCH both times.
//  opcode 0010011 -> FAULT, fault_code=01; stays until rst; instret unchanged; rst returns to FETCH.
//  sw, mem_ready never asserted, MEM_TIMEOUT=16 -> FAULT code 10 after 16 request cycles. Rerun with ready at cycle 16: no fault.
//  rst asserted in MEM_RD -> outputs 0 that cycle, FETCH next, no retire. instret preset near 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32 multi-cycle control path: opcodes, FSM
// state encodings, ALU operation selects and fault codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Encodings are visible on state_dbg, so they are pinned explicitly.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_LD_WB    = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_FAULT    = 4'd15
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts wait cycles of an outstanding memory request; expired is high in the
// wait cycle that would bring the count to MEM_TIMEOUT (never when MEM_TIMEOUT=0).
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit ENABLED = (MEM_TIMEOUT > 0);

    logic [W-1:0] cnt;

    // Saturates at LAST; the FSM leaves the request state on the following edge anyway.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = ENABLED && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for an RV32 subset (R-type, lw, sw, beq) with
// a req/ready memory handshake, timeout and illegal-opcode faults, and instret.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             aluout_we,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             pc_write,
    output logic             pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [3:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [CNT_W-1:0] instret_q;
    logic             expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fault_code_q <= FAULT_NONE;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Any state change restarts the wait count, so each request gets a fresh budget.
    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .inc     (mem_req && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        aluout_we    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_OP_ADD;
        reg_write    = 1'b0;
        mem2reg      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        retire       = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = 1'b1;
                    aluout_we = 1'b1;
                    case (opcode)
                        OPC_R:                state_d = ST_EXEC_R;
                        OPC_LOAD, OPC_STORE:  state_d = ST_MEM_ADDR;
                        OPC_BRANCH:           state_d = ST_BRANCH;
                        default: begin
                            state_d      = ST_FAULT;
                            fault_code_d = FAULT_ILLEGAL;
                        end
                    endcase
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                    aluout_we = 1'b1;
                    state_d   = ST_R_WB;
                end
                ST_R_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 1'b1;
                    aluout_we = 1'b1;
                    state_d   = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_LD_WB;
                    end
                end
                ST_LD_WB: begin
                    reg_write = 1'b1;
                    mem2reg   = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
                // ALUOut still holds the target computed in DECODE; the subtract only feeds zero.
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_SUB;
                    pc_write  = 1'b1;
                    pc_src    = zero;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase

            // A ready arriving in the expiring cycle completes the transfer instead.
            if (mem_req && !mem_ready && expired) begin
                state_d      = ST_FAULT;
                fault_code_d = FAULT_TIMEOUT;
            end
        end
    end

    assign fault      = !rst && (state_q == ST_FAULT);
    assign fault_code = rst ? FAULT_NONE : fault_code_q;
    assign instret    = rst ? '0 : instret_q;
    assign state_dbg  = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus pushes per-instruction
// expectations from a latency/count model; a monitor checks each retire or fault.
module tb_multicycle_ctrl_fsm;

    localparam int TO    = 16;
    localparam int CW    = 5;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, iord, ir_write, aluout_we;
    logic          alu_src_a, alu_src_b, reg_write, mem2reg;
    logic          pc_write, pc_src, retire, fault;
    logic [1:0]    alu_op, fault_code;
    logic [CW-1:0] instret;
    logic [3:0]    state_dbg;

    typedef struct {
        int kind;
        int pc_src;
        int mem2reg;
        int lat;
        int nreq;
        int nrw;
        int inst;
        int code;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   model_cnt = 0;

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .aluout_we  (aluout_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem2reg    (mem2reg),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .retire     (retire),
        .instret    (instret),
        .fault      (fault),
        .fault_code (fault_code),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected outcome from instruction class, wait states and the timeout rule.
    function automatic exp_t model(input logic [6:0] opc, input int fw, input int mw, input bit z);
        exp_t e;
        bit   is_mem;
        e = '{kind: 15, pc_src: 0, mem2reg: 0, lat: 0, nreq: fw + 1, nrw: 0,
              inst: model_cnt % (1 << CW), code: 0};
        is_mem = (opc == 7'b0000011) || (opc == 7'b0100011);
        if (is_mem && mw >= TO) begin
            e.code = 2;
            e.lat  = 3 + fw + TO + 1;
            e.nreq = fw + 1 + TO;
        end else begin
            case (opc)
                7'b0110011: begin e.kind = 3; e.lat = 4 + fw; e.nrw = 1; end
                7'b0000011: begin e.kind = 6; e.lat = 5 + fw + mw; e.nreq = fw + mw + 2;
                                  e.nrw = 1; e.mem2reg = 1; end
                7'b0100011: begin e.kind = 7; e.lat = 4 + fw + mw; e.nreq = fw + mw + 2; end
                7'b1100011: begin e.kind = 8; e.lat = 3 + fw; e.pc_src = int'(z); end
                default:    begin e.code = 1; e.lat = 3 + fw; end
            endcase
        end
        return e;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_output("rst_outputs_zero",
                     int'({mem_req, mem_we, iord, ir_write, aluout_we, alu_src_a, alu_src_b,
                           alu_op, reg_write, mem2reg, pc_write, pc_src, retire, fault,
                           fault_code, state_dbg, instret} != '0), 0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        model_cnt = 0;
        #1;
        check_output("reset_state", int'(state_dbg), 0);
        check_output("reset_instret", int'(instret), 0);
        check_output("reset_fetch_req", int'({mem_req, iord, fault}), 4);
    endtask

    // Starts just after a negedge in FETCH; returns just after the negedge following retire/fault.
    task automatic apply_stimulus(input logic [6:0] opc, input int fw, input int mw, input bit z);
        int wcnt = 0;
        bit done = 0;
        exp_t e;
        e = model(opc, fw, mw, z);
        exp_q.push_back(e);
        if (e.kind != 15) model_cnt++;
        opcode = opc;
        zero   = z;
        for (int i = 0; i < 200 && !done; i++) begin
            if (mem_req) begin
                mem_ready = (wcnt == (iord ? mw : fw));
                wcnt      = mem_ready ? 0 : wcnt + 1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            done = retire || fault;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check_output("instr_completed", int'(done), 1);
    endtask

    // Monitor: tracks per-instruction latency and strobe counts, pops on retire or fault entry.
    initial begin : monitor
        int   cyc = 0, start = 0, nreq = 0, nrw = 0, prev_state = 15;
        bit   prev_fault = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (rst) begin
                prev_state = 15;
                prev_fault = 0;
            end else begin
                if (state_dbg == 4'd0 && prev_state != 0) begin
                    start = cyc;
                    nreq  = 0;
                    nrw   = 0;
                end
                nreq += int'(mem_req);
                nrw  += int'(reg_write);
                if (retire || (fault && !prev_fault)) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_event", int'(state_dbg), 99);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("event_state", int'(state_dbg), e.kind);
                        check_output("latency", cyc - start + 1, e.lat);
                        check_output("mem_req_cycles", nreq, e.nreq);
                        check_output("instret", int'(instret), e.inst);
                        if (retire) begin
                            check_output("pc_src", int'(pc_src), e.pc_src);
                            check_output("mem2reg", int'(mem2reg), e.mem2reg);
                            check_output("aluout_we_at_retire", int'(aluout_we), 0);
                            check_output("reg_write_count", nrw, e.nrw);
                        end else begin
                            check_output("fault_code", int'(fault_code), e.code);
                        end
                    end
                end
                prev_state = int'(state_dbg);
                prev_fault = fault;
            end
        end
    end

    task automatic check_fault_sticky(input int code);
        repeat (3) @(negedge clk);
        #1;
        check_output("fault_sticky_state", int'(state_dbg), 15);
        check_output("fault_sticky_code", int'(fault_code), code);
    endtask

    initial begin : stimulus
        logic [6:0] legal [4];
        legal[0] = 7'b0110011;
        legal[1] = 7'b0000011;
        legal[2] = 7'b0100011;
        legal[3] = 7'b1100011;

        apply_reset();
        apply_stimulus(7'b0110011, 0, 0, 1'b0);
        apply_stimulus(7'b0000011, 0, 3, 1'b0);
        apply_stimulus(7'b1100011, 0, 0, 1'b1);
        apply_stimulus(7'b1100011, 0, 0, 1'b0);
        apply_stimulus(7'b0100011, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(legal[$urandom_range(0, 3)], $urandom_range(0, 3),
                           $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        apply_stimulus(7'b0010011, 1, 0, 1'b0);
        check_fault_sticky(1);
        apply_reset();

        apply_stimulus(7'b0110011, 0, 0, 1'b0);
        apply_stimulus(7'b0100011, 0, NEVER, 1'b0);
        check_fault_sticky(2);
        apply_reset();
        apply_stimulus(7'b0100011, 0, TO - 1, 1'b0);
        apply_stimulus(7'b0000011, 2, TO - 1, 1'b0);

        // Abort a load mid-request: reset must suppress the retire.
        opcode = 7'b0000011;
        for (int i = 0; i < 20 && state_dbg != 4'd5; i++) begin
            mem_ready = mem_req && !iord;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check_output("reached_mem_rd", int'(state_dbg), 5);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_output("rst_in_mem_rd_zero", int'({mem_req, iord, retire, reg_write, state_dbg}), 0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        model_cnt = 0;
        #1;
        check_output("after_abort_state", int'(state_dbg), 0);
        check_output("after_abort_instret", int'(instret), 0);
        apply_stimulus(7'b0110011, 1, 0, 1'b0);

        repeat (4) @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
